// File: rtl/mult_div_engine.sv
// mult_div_engine
//   Iterative radix-2 multiply/divide unit that writes the HI/LO register
//   pair. One operation is in flight at a time and a fixed run takes 34
//   cycles from start to the write strobe.
//
//   Optional build macro: MULT_EARLY_TERM_EN
//     When defined, a multiply finishes as soon as the remaining multiplier
//     bits are all zero. Divides always run the full count.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     start      : launch an operation (only looked at while idle)
//     op         : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     src_a      : multiplicand / dividend
//     src_b      : multiplier / divisor
//     flush      : abandon the operation in progress
//     busy       : an operation is in progress
//     write      : one-cycle HI/LO write strobe
//     write_data : {hi, lo}; multiply = product, divide = {remainder, quotient}
module mult_div_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic                 flush,
  output logic                 busy,
  output logic                 write,
  output logic [2*WIDTH-1:0]   write_data
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  // Latched command
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  // Result sign flags recorded in PREP
  logic               neg_main_q;
  logic               neg_rem_q;

  logic [CNT_W-1:0]   count;

  // Multiply datapath
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;

  // Divide datapath
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH:0]     divisor;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     ext_b;
  logic [WIDTH:0]     abs_a;
  logic [WIDTH:0]     abs_b;
  logic [WIDTH:0]     mplier_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;
  logic               unused_bits;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Operands are widened by one bit so that the magnitude of the most
  // negative value is representable.
  assign ext_a = is_signed ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
  assign ext_b = is_signed ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
  assign abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
  assign abs_b = ext_b[WIDTH] ? -ext_b : ext_b;

  assign mplier_shift = mplier >> 1;

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor. A clear top bit of the
  // difference means the subtraction fits and the quotient bit is 1.
  assign div_diff = {1'b0, rem, quot[WIDTH-1]} - {1'b0, divisor};

  assign prod_fix = neg_main_q ? -acc  : acc;
  assign quot_fix = neg_main_q ? -quot : quot;
  assign rem_fix  = neg_rem_q  ? -rem  : rem;

  // Divide by zero bypasses the iteration result: the remainder is the raw
  // dividend and the quotient is all ones, whatever the signedness.
  always_comb begin
    result = prod_fix;
    if (is_div) begin
      if (b_q == '0) begin
        result = {a_q, {WIDTH{1'b1}}};
      end else begin
        result = {rem_fix, quot_fix};
      end
    end
  end

  // The difference never exceeds WIDTH bits when it is kept, so bit WIDTH
  // carries no information.
  assign unused_bits = div_diff[WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Flush beats everything outside IDLE, including the
  // FIX cycle that would otherwise load the result; inside IDLE it only
  // suppresses a simultaneous start.
  always_comb begin
    state_next = state;
    if (state != IDLE && flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state_next = PREP;
          end
        end
        PREP: begin
          state_next = RUN;
`ifdef MULT_EARLY_TERM_EN
          if (!is_div && abs_b == '0) begin
            state_next = FIX;
          end
`endif
        end
        RUN: begin
          if (count == CNT_W'(WIDTH - 1)) begin
            state_next = FIX;
          end
`ifdef MULT_EARLY_TERM_EN
          else if (!is_div && mplier_shift == '0) begin
            state_next = FIX;
          end
`endif
        end
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers. Work done in a cycle that is being flushed is
  // harmless because the next start reloads everything in PREP; only the
  // result load in FIX has to respect flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      count      <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quot       <= '0;
      divisor    <= '0;
      write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q <= op;
            a_q  <= src_a;
            b_q  <= src_b;
          end
        end
        PREP: begin
          neg_main_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q  <= is_signed & a_q[WIDTH-1];
          count      <= '0;
          acc        <= '0;
          mcand      <= {{(WIDTH-1){1'b0}}, abs_a};
          mplier     <= abs_b;
          rem        <= '0;
          quot       <= abs_a[WIDTH-1:0];
          divisor    <= abs_b;
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
              rem  <= div_diff[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
              quot <= {quot[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier_shift;
          end
        end
        FIX: begin
          if (!flush) begin
            write_data <= result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The strobe is exactly the single DONE cycle, and busy covers every
  // non-idle state, so both fall out of the state register directly.
  assign busy  = (state != IDLE);
  assign write = (state == DONE);

endmodule
